if_id_skid_reg: RTL and testbench

IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

---
 rtl/if_id_skid_reg.sv | 142 ++++++++++++++
 tb/tb_if_id_skid_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer, so in_ready can be registered
// without losing throughput. Also decodes the instruction fields and counts stalls and flushes.
module if_id_skid_reg #(
  parameter int unsigned  PC_W      = 32,
  parameter int unsigned  INSTR_W   = 32,
  parameter logic [31:0]  NOP_INSTR = 32'h0000_0013,
  parameter int unsigned  CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [PC_W-1:0]    in_pc_plus_4,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc_plus_4,
  output logic [INSTR_W-1:0] out_instr,
  output logic [6:0]         opcode,
  output logic [4:0]         rd,
  output logic [2:0]         func_3,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic               func_7_bit_6,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

  logic               main_v_q, main_v_n;
  logic               skid_v_q, skid_v_n;
  logic               in_ready_q, in_ready_n;
  logic [PC_W-1:0]    main_pc_q, main_pc_n, main_pc4_q, main_pc4_n;
  logic [INSTR_W-1:0] main_instr_q, main_instr_n;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_n, skid_pc4_q, skid_pc4_n;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_n;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_n, flush_cnt_q, flush_cnt_n;

  logic accept, release_main, stall_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q     <= 1'b0;
      skid_v_q     <= 1'b0;
      in_ready_q   <= 1'b1;
      main_pc_q    <= '0;
      main_pc4_q   <= '0;
      main_instr_q <= NOP_W;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
      skid_instr_q <= NOP_W;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      main_v_q     <= main_v_n;
      skid_v_q     <= skid_v_n;
      in_ready_q   <= in_ready_n;
      main_pc_q    <= main_pc_n;
      main_pc4_q   <= main_pc4_n;
      main_instr_q <= main_instr_n;
      skid_pc_q    <= skid_pc_n;
      skid_pc4_q   <= skid_pc4_n;
      skid_instr_q <= skid_instr_n;
      stall_cnt_q  <= stall_cnt_n;
      flush_cnt_q  <= flush_cnt_n;
    end
  end

  // Entry movement: release drains main (refilled from skid), then an accepted input
  // lands in whichever slot is free afterwards, keeping skid younger than main.
  always_comb begin
    main_v_n     = main_v_q;
    skid_v_n     = skid_v_q;
    main_pc_n    = main_pc_q;
    main_pc4_n   = main_pc4_q;
    main_instr_n = main_instr_q;
    skid_pc_n    = skid_pc_q;
    skid_pc4_n   = skid_pc4_q;
    skid_instr_n = skid_instr_q;
    stall_cnt_n  = stall_cnt_q;
    flush_cnt_n  = flush_cnt_q;

    accept       = in_valid && in_ready_q;
    release_main = main_v_q && out_ready;
    stall_evt    = main_v_q && !out_ready && !flush;

    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else begin
      if (release_main) begin
        main_v_n = 1'b0;
        if (skid_v_q) begin
          main_v_n     = 1'b1;
          skid_v_n     = 1'b0;
          main_pc_n    = skid_pc_q;
          main_pc4_n   = skid_pc4_q;
          main_instr_n = skid_instr_q;
        end
      end
      if (accept) begin
        if (!main_v_n) begin
          main_v_n     = 1'b1;
          main_pc_n    = in_pc;
          main_pc4_n   = in_pc_plus_4;
          main_instr_n = in_instr;
        end else begin
          skid_v_n     = 1'b1;
          skid_pc_n    = in_pc;
          skid_pc4_n   = in_pc_plus_4;
          skid_instr_n = in_instr;
        end
      end
    end
    in_ready_n = !skid_v_n;

    if (stall_evt && (stall_cnt_q != '1))
      stall_cnt_n = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1))
      flush_cnt_n = flush_cnt_q + CNT_W'(1);
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_v_q;
  assign out_pc        = main_pc_q;
  assign out_pc_plus_4 = main_pc4_q;
  assign out_instr     = main_v_q ? main_instr_q : NOP_W;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

  assign opcode        = out_instr[6:0];
  assign rd            = out_instr[11:7];
  assign func_3        = out_instr[14:12];
  assign rs1           = out_instr[19:15];
  assign rs2           = out_instr[24:20];
  assign func_7_bit_6  = out_instr[30];

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Randomized bench for if_id_skid_reg: the stage is modelled as a two-deep FIFO
// and compared against the DUT every cycle, plus directed scenarios.
module tb_if_id_skid_reg;

  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned CMAX  = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_pc_plus_4, in_instr;
  logic [31:0] out_pc, out_pc_plus_4, out_instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  func_3;
  logic        func_7_bit_6;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  if_id_skid_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_plus_4(in_pc_plus_4), .in_instr(in_instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_plus_4(out_pc_plus_4), .out_instr(out_instr), .opcode(opcode), .rd(rd),
    .func_3(func_3), .rs1(rs1), .rs2(rs2), .func_7_bit_6(func_7_bit_6),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  int unsigned m_stall, m_flush;
  logic [31:0] last_pc, last_pc4;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_stall  = 0;
    m_flush  = 0;
    last_pc  = '0;
    last_pc4 = '0;
  endtask

  task automatic check_all();
    logic [31:0] ei;
    if (q.size() > 0) begin
      last_pc  = q[0].pc;
      last_pc4 = q[0].pc4;
      ei       = q[0].instr;
    end else begin
      ei = NOP;
    end
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("out_pc", 64'(out_pc), 64'(last_pc));
    check("out_pc_plus_4", 64'(out_pc_plus_4), 64'(last_pc4));
    check("out_instr", 64'(out_instr), 64'(ei));
    check("opcode", 64'(opcode), 64'(ei[6:0]));
    check("rd", 64'(rd), 64'(ei[11:7]));
    check("func_3", 64'(func_3), 64'(ei[14:12]));
    check("rs1", 64'(rs1), 64'(ei[19:15]));
    check("rs2", 64'(rs2), 64'(ei[24:20]));
    check("func_7_bit_6", 64'(func_7_bit_6), 64'(ei[30]));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
  endtask

  // One clock cycle: drive, clock, advance the FIFO model, compare.
  task automatic tick(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic ordy, input logic fl);
    ent_t e;
    bit   acc, rel;
    in_valid     = v;
    in_pc        = pc;
    in_pc_plus_4 = pc + 32'd4;
    in_instr     = instr;
    out_ready    = ordy;
    flush        = fl;
    acc = v && (q.size() < 2);
    rel = (q.size() > 0) && ordy;
    if ((q.size() > 0) && !ordy && !fl && (m_stall < CMAX)) m_stall++;
    if (fl && (m_flush < CMAX)) m_flush++;
    e.pc = pc; e.pc4 = pc + 32'd4; e.instr = instr;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (rel) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
    check_all();
  endtask

  // Reset asserted mid-cycle; effect must be visible before the next edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_pc_plus_4 = '0; in_instr = '0;
    out_ready = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #3 rst_n = 1'b1;

    // Streaming at full rate
    tick(1, 32'h0, 32'h0000_0093, 1, 0);
    check("stream_pc0", 64'(out_pc), 64'h0);
    tick(1, 32'h4, 32'h0010_0113, 1, 0);
    check("stream_pc1", 64'(out_pc), 64'h4);
    tick(1, 32'h8, 32'h0020_0193, 1, 0);
    check("stream_pc2", 64'(out_pc), 64'h8);
    check("stream_valid", 64'(out_valid), 64'd1);
    check("stream_stall", 64'(stall_cnt), 64'd0);
    tick(0, 32'h0, 32'h0, 1, 0);

    // Backpressure fills main then skid
    async_reset();
    tick(1, 32'h10, 32'h0000_1111, 0, 0);
    tick(1, 32'h14, 32'h0000_2222, 0, 0);
    check("bp_main_pc", 64'(out_pc), 64'h10);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    tick(1, 32'h99, 32'h0000_9999, 0, 0);
    check("bp_hold_pc", 64'(out_pc), 64'h10);
    tick(0, 32'h0, 32'h0, 1, 0);
    check("bp_drain_pc", 64'(out_pc), 64'h14);
    tick(0, 32'h0, 32'h0, 1, 0);
    check("bp_empty", 64'(out_valid), 64'd0);
    check("bp_stall", 64'(stall_cnt), 64'd2);

    // Flush with skid full and a same-cycle input
    async_reset();
    tick(1, 32'h10, 32'h0000_1111, 0, 0);
    tick(1, 32'h14, 32'h0000_2222, 0, 0);
    tick(1, 32'h18, 32'h0000_3333, 0, 1);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_instr", 64'(out_instr), 64'(NOP));
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_cnt", 64'(flush_cnt), 64'd1);
    repeat (3) tick(0, 32'h0, 32'h0, 1, 0);
    // Flush also kills an input accepted in the same cycle
    tick(1, 32'h20, 32'h0000_4444, 0, 0);
    tick(1, 32'h24, 32'h0000_5555, 1, 1);
    tick(0, 32'h0, 32'h0, 1, 0);
    check("fl2_valid", 64'(out_valid), 64'd0);

    // Decode of sub x10,x10,x11
    async_reset();
    tick(1, 32'h40, 32'h40B5_0533, 0, 0);
    check("dec_opcode", 64'(opcode), 64'h33);
    check("dec_rd", 64'(rd), 64'd10);
    check("dec_func_3", 64'(func_3), 64'd0);
    check("dec_rs1", 64'(rs1), 64'd10);
    check("dec_rs2", 64'(rs2), 64'd11);
    check("dec_f7b6", 64'(func_7_bit_6), 64'd1);

    // Stall counter saturation
    repeat (20) tick(0, 32'h0, 32'h0, 0, 0);
    check("sat_stall", 64'(stall_cnt), 64'd15);

    // Async reset while holding a valid entry, then first accept goes to main
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    async_reset();
    tick(1, 32'h80, 32'h0000_7777, 0, 0);
    check("post_rst_main", 64'(out_pc), 64'h80);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = $urandom() & 32'hFFFF_FFFC;
      tick(($urandom_range(0, 9) < 7), pc, $urandom(), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 39) == 0));
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
